screen_sequencer: RTL
=====================

# screen_sequencer

Top-level screen controller for the flappy-bird display pipeline. Sequences the game through its intro, play, dying and game-over phases. Drives the enable and image-select inputs of the intro/game-over ROM overlays. Provides frame-synchronous pacing (blink, death pause, restart lockout) derived from the VGA scan counters.

## Interface
- `FRAME_H`, default 10'd0: h_line value marking frame start.
- `FRAME_V`, default 10'd0: v_line value marking frame start.
- `BLINK_FRAMES`, default 30: frames per `img_sel` toggle in INTRO/GAMEOVER.
- `DIE_FRAMES`, default 45: frames spent in DYING before GAMEOVER.
- `LOCK_FRAMES`, default 60: frames after entering GAMEOVER during which the button is ignored.
- `ATTRACT_FRAMES`, default 600: GAMEOVER idle frames before auto-return to INTRO. Used only with the macro enabled.
- `clk` input 1: system/pixel clock.
- `rst` input 1: synchronous, active-high reset.
- `h_line` input 10: current horizontal scan position.
- `v_line` input 10: current vertical scan position.
- `flap_btn` input 1: raw, asynchronous player button.
- `collision` input 1: level, asserted by the bird/pipe logic while a hit is detected.
- `intro_en` output 1: enables the intro overlay.
- `gameover_en` output 1: enables the game-over overlay.
- `img_sel` output 1: overlay image select, i.e. the overlay's `control` input. 1 selects the low nibble, 0 the high nibble.
- `play_en` output 1: world/bird motion enable.
- `game_rst` output 1: one-cycle pulse that clears score, bird and pipes.
- `flap` output 1: one-cycle synchronized button press, forwarded in PLAY only.
- `frame_tick` output 1: one-cycle pulse per frame.
- `state` output 2: 0 INTRO, 1 PLAY, 2 DYING, 3 GAMEOVER.

## Operation
- **Button path**
  - `flap_btn` passes through a 2-flop synchronizer.
  - A rising-edge detector on the synchronized signal produces `press`, high for 1 cycle.
- **Frame tick**
  - `hit = (h_line==FRAME_H && v_line==FRAME_V)`.
  - `frame_tick` = `hit` and not `hit` of the previous cycle. This gives exactly one pulse per frame even when the pixel position is held for several clocks.
- **Frame counter**
  - `fcnt` is 10 bits. It clears on every state change and increments on `frame_tick`.
  - It saturates at 1023 and never wraps.
- **Blink**
  - `bcnt` increments on `frame_tick` while in INTRO or GAMEOVER.
  - When `bcnt` reaches `BLINK_FRAMES-1` on a tick, `bcnt` goes to 0 and `img_sel` toggles.
  - On entry to INTRO or GAMEOVER, `bcnt` is cleared and `img_sel` is set to 1.
- **State machine**
  - INTRO → PLAY on `press`. `game_rst` pulses in the same cycle as the transition.
  - PLAY → DYING on `collision`. A `press` in PLAY produces `flap`.
  - DYING → GAMEOVER on a `frame_tick` with `fcnt == DIE_FRAMES-1`. A `press` in DYING is discarded.
  - GAMEOVER → INTRO on `press` with `fcnt >= LOCK_FRAMES`. A `press` during lockout is discarded and not queued.
- **Simultaneous events**
  - `collision` and `press` in the same PLAY cycle: DYING is taken and `flap` still pulses.
  - A state-change cycle coinciding with `frame_tick`: the counter clear wins, so `fcnt = 0`.
- **Output decode (registered)**
  - `intro_en = (state==INTRO)`.
  - `gameover_en = (state==GAMEOVER)`.
  - `play_en = (state==PLAY)`.
  - During DYING all three are 0; the world is frozen and no overlay is shown.
- **Reset values**
  - `state` = INTRO, `intro_en` = 1, `img_sel` = 1.
  - All other outputs 0.
  - `fcnt`, `bcnt` and the synchronizer/edge flops are 0.
  - Reset mid-game returns to INTRO on the next edge without emitting `game_rst`.

## Timing
- **`flap_btn` rise to `press`:** 3 clocks (2 sync + 1 edge register).
- **`press` to `state` change and to `game_rst`/`flap`:** registered on the next edge, so the total from `flap_btn` is 4 clocks.
- **`collision` to `state`=DYING:** 1 clock. `play_en` falls on the same edge.
- **`frame_tick`:** asserted the clock after the first `hit` cycle.
- **Outputs:** all outputs are registered; none is combinational from an input.

## Configuration
- **`ATTRACT_TIMEOUT_EN` defined:**
  - In GAMEOVER, a `frame_tick` with `fcnt == ATTRACT_FRAMES-1` and no `press` returns the block to INTRO.
  - No `game_rst` is issued on this auto-return.
- **`ATTRACT_TIMEOUT_EN` undefined:**
  - GAMEOVER is left only on `press`.
  - `ATTRACT_FRAMES` is unused.

## Test plan
- **Reset:** assert `rst` 2 cycles.
  - Expect `state`=0, `intro_en`=1, `img_sel`=1, and all other outputs 0.
  - Sweep h/v for 3 frames: `frame_tick` fires 3 times, 1 clock each.
- **Intro blink:** run 60 frames in INTRO.
  - `img_sel` toggles at frames 30 and 60.
  - Pulse `flap_btn`: 4 clocks later `state`=1, `game_rst`=1 for 1 clock, `play_en`=1.
- **Play:** in PLAY, pulse `flap_btn` twice, then hold `collision`.
  - Expect two 1-cycle `flap` pulses, then `state`=2 one clock after `collision`.
  - After 45 frames, `state`=3 and `gameover_en`=1.
- **Lockout:** in GAMEOVER, press at frame 10.
  - Expect no state change.
  - Press at frame 60: `state`=0, `intro_en`=1.
- **Simultaneous events and reset mid-operation:**
  - `collision` and `press` land in the same PLAY cycle: `flap`=1 and `state`=2.
  - `rst` asserted during DYING: INTRO next edge, and `game_rst` stays 0.
- **Attract timeout (`ATTRACT_TIMEOUT_EN` defined):** idle 600 frames in GAMEOVER.
  - Expect `state`=0.
  - With the macro undefined, `state` remains 3 after 1000 frames.

Source files
------------

// File: rtl/screen_sequencer.sv
// -----------------------------------------------------------------------------
// screen_sequencer
//
// Top-level screen controller for the flappy-bird display pipeline. It steps the
// game through INTRO -> PLAY -> DYING -> GAMEOVER -> INTRO. It drives the
// enable and image-select inputs of the intro/game-over ROM overlays. All
// pacing (overlay blink, death pause, restart lockout) is counted in frames,
// using a frame tick derived from the VGA scan position.
//
// Optional feature macro: ATTRACT_TIMEOUT_EN
//   When defined, GAMEOVER returns to INTRO by itself after ATTRACT_FRAMES idle
//   frames. No game_rst is issued on that return.
//   When undefined, GAMEOVER is left only on a button press.
//
// Ports
//   clk          in   system/pixel clock
//   rst          in   synchronous, active-high reset
//   h_line[9:0]  in   current horizontal scan position
//   v_line[9:0]  in   current vertical scan position
//   flap_btn     in   raw asynchronous player button
//   collision    in   level, high while the bird/pipe logic detects a hit
//   intro_en     out  intro overlay enable
//   gameover_en  out  game-over overlay enable
//   img_sel      out  overlay image select (1 = low nibble, 0 = high nibble)
//   play_en      out  world/bird motion enable
//   game_rst     out  one-cycle pulse clearing score, bird and pipes
//   flap         out  one-cycle synchronized button press, PLAY only
//   frame_tick   out  one-cycle pulse per frame
//   state[1:0]   out  0 INTRO, 1 PLAY, 2 DYING, 3 GAMEOVER
// -----------------------------------------------------------------------------
module screen_sequencer #(
    parameter logic [9:0] FRAME_H        = 10'd0,
    parameter logic [9:0] FRAME_V        = 10'd0,
    parameter int         BLINK_FRAMES   = 30,
    parameter int         DIE_FRAMES     = 45,
    parameter int         LOCK_FRAMES    = 60,
    parameter int         ATTRACT_FRAMES = 600
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] h_line,
    input  logic [9:0] v_line,
    input  logic       flap_btn,
    input  logic       collision,
    output logic       intro_en,
    output logic       gameover_en,
    output logic       img_sel,
    output logic       play_en,
    output logic       game_rst,
    output logic       flap,
    output logic       frame_tick,
    output logic [1:0] state
);

    localparam logic [1:0] ST_INTRO    = 2'd0;
    localparam logic [1:0] ST_PLAY     = 2'd1;
    localparam logic [1:0] ST_DYING    = 2'd2;
    localparam logic [1:0] ST_GAMEOVER = 2'd3;

    localparam logic [9:0] BLINK_LAST   = 10'(BLINK_FRAMES - 1);
    localparam logic [9:0] DIE_LAST     = 10'(DIE_FRAMES - 1);
    localparam logic [9:0] LOCK_MIN     = 10'(LOCK_FRAMES);
    localparam logic [9:0] ATTRACT_LAST = 10'(ATTRACT_FRAMES - 1);
    localparam logic [9:0] FCNT_MAX     = 10'd1023;

    // Button synchronizer and edge detector
    logic       sync1_q, sync1_d;
    logic       sync2_q, sync2_d;
    logic       sync3_q, sync3_d;
    logic       press_q, press_d;

    // Frame tick
    logic       hit;
    logic       hit_q, hit_d;
    logic       frame_tick_q, frame_tick_d;

    // Sequencer state and counters
    logic [1:0] state_q, state_d;
    logic [9:0] fcnt_q, fcnt_d;
    logic [9:0] bcnt_q, bcnt_d;
    logic       img_sel_q, img_sel_d;

    // Registered outputs
    logic       intro_en_q, intro_en_d;
    logic       gameover_en_q, gameover_en_d;
    logic       play_en_q, play_en_d;
    logic       game_rst_q, game_rst_d;
    logic       flap_q, flap_d;

    logic       state_change;
    logic       overlay_state_q;
    logic       overlay_state_d;
    logic       attract_to;

`ifdef ATTRACT_TIMEOUT_EN
    // An actual press takes priority over the idle timeout.
    assign attract_to = frame_tick_q && !press_q && (fcnt_q == ATTRACT_LAST);
`else
    logic unused_attract;
    assign attract_to     = 1'b0;
    assign unused_attract = ^ATTRACT_LAST;
`endif

    always_comb begin
        // Two-flop synchronizer. A third flop holds the previous synchronized
        // value, so press_q is a registered one-cycle rising-edge pulse.
        sync1_d = flap_btn;
        sync2_d = sync1_q;
        sync3_d = sync2_q;
        press_d = sync2_q & ~sync3_q;

        // The scan position may sit on the frame-start pixel for several
        // clocks. Only the first hit cycle produces a tick.
        hit          = (h_line == FRAME_H) && (v_line == FRAME_V);
        hit_d        = hit;
        frame_tick_d = hit & ~hit_q;

        state_d    = state_q;
        game_rst_d = 1'b0;
        flap_d     = 1'b0;
        case (state_q)
            ST_INTRO: begin
                if (press_q) begin
                    state_d    = ST_PLAY;
                    game_rst_d = 1'b1;
                end
            end
            ST_PLAY: begin
                // A press coinciding with a collision still emits a flap.
                flap_d = press_q;
                if (collision) begin
                    state_d = ST_DYING;
                end
            end
            ST_DYING: begin
                if (frame_tick_q && (fcnt_q == DIE_LAST)) begin
                    state_d = ST_GAMEOVER;
                end
            end
            ST_GAMEOVER: begin
                // Presses during lockout are dropped, not remembered.
                if (press_q && (fcnt_q >= LOCK_MIN)) begin
                    state_d = ST_INTRO;
                end else if (attract_to) begin
                    state_d = ST_INTRO;
                end
            end
            default: state_d = ST_INTRO;
        endcase

        state_change    = (state_d != state_q);
        overlay_state_q = (state_q == ST_INTRO) || (state_q == ST_GAMEOVER);
        overlay_state_d = (state_d == ST_INTRO) || (state_d == ST_GAMEOVER);

        // Frame counter: a state change clears it even if a tick lands in the
        // same cycle. It saturates instead of wrapping.
        fcnt_d = fcnt_q;
        if (state_change) begin
            fcnt_d = 10'd0;
        end else if (frame_tick_q && (fcnt_q != FCNT_MAX)) begin
            fcnt_d = fcnt_q + 10'd1;
        end

        // Overlay blink. Each overlay phase starts on image 1 with a fresh
        // count. The value is held while no overlay is visible.
        bcnt_d    = bcnt_q;
        img_sel_d = img_sel_q;
        if (state_change && overlay_state_d) begin
            bcnt_d    = 10'd0;
            img_sel_d = 1'b1;
        end else if (frame_tick_q && overlay_state_q) begin
            if (bcnt_q == BLINK_LAST) begin
                bcnt_d    = 10'd0;
                img_sel_d = ~img_sel_q;
            end else begin
                bcnt_d = bcnt_q + 10'd1;
            end
        end

        // Enables are decoded from the next state. They then switch on the
        // same edge as the state register.
        intro_en_d    = (state_d == ST_INTRO);
        gameover_en_d = (state_d == ST_GAMEOVER);
        play_en_d     = (state_d == ST_PLAY);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q       <= 1'b0;
            sync2_q       <= 1'b0;
            sync3_q       <= 1'b0;
            press_q       <= 1'b0;
            hit_q         <= 1'b0;
            frame_tick_q  <= 1'b0;
            state_q       <= ST_INTRO;
            fcnt_q        <= 10'd0;
            bcnt_q        <= 10'd0;
            img_sel_q     <= 1'b1;
            intro_en_q    <= 1'b1;
            gameover_en_q <= 1'b0;
            play_en_q     <= 1'b0;
            game_rst_q    <= 1'b0;
            flap_q        <= 1'b0;
        end else begin
            sync1_q       <= sync1_d;
            sync2_q       <= sync2_d;
            sync3_q       <= sync3_d;
            press_q       <= press_d;
            hit_q         <= hit_d;
            frame_tick_q  <= frame_tick_d;
            state_q       <= state_d;
            fcnt_q        <= fcnt_d;
            bcnt_q        <= bcnt_d;
            img_sel_q     <= img_sel_d;
            intro_en_q    <= intro_en_d;
            gameover_en_q <= gameover_en_d;
            play_en_q     <= play_en_d;
            game_rst_q    <= game_rst_d;
            flap_q        <= flap_d;
        end
    end

    assign intro_en    = intro_en_q;
    assign gameover_en = gameover_en_q;
    assign img_sel     = img_sel_q;
    assign play_en     = play_en_q;
    assign game_rst    = game_rst_q;
    assign flap        = flap_q;
    assign frame_tick  = frame_tick_q;
    assign state       = state_q;

endmodule
